cim_weight_loader: RTL and testbench
====================================

# cim_weight_loader

Initiator for the CIM unit's standard-memory port. Accepts a load command and a 64-beat weight stream, writes rows into a non-active core via STDW, optionally reads them back for checking, then hands the freshly loaded core to CIM (ping-pong swap). It sits between the weight-fetch path and the 8-core CIM unit, and owns `CIM_Core_A`, `STD_Core_A`, `STDW`, `STDR`, `STD_row_A` and `weight_in`.

## Interface
- `ROWS`, 64: rows per core; beats per load.
- `WW`, 288: row width (4b x 8 x 9).
- `RD_LAT`, 1: cycles from `STDR` asserted to valid `weight_out` (range 1-3).
- `INIT_CORE`, 0: `CIM_Core_A` value after reset.

- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous assert, active-high.
- `cmd_valid`  in  1  load command valid.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_core`  in  3  core to load.
- `cmd_swap`  in  1  make the loaded core the CIM core on completion.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  high only in WRITE.
- `w_data`  in  WW  row data; beat k goes to row k.
- `CIM_Core_A`  out  3  active CIM core (registered).
- `STD_Core_A`  out  3  standard R/W core (registered).
- `STDW`  out  1  write strobe (registered).
- `STDR`  out  1  read strobe (registered).
- `STD_row_A`  out  6  row address (registered).
- `weight_in`  out  WW  write data (registered).
- `weight_out`  in  WW  readback data.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle pulse at end of a load.
- `err`  out  1  one-cycle pulse when a command is rejected.
- `verify_fail`  out  1  sticky readback mismatch flag.

## Operation
- States: IDLE, WRITE, VERIFY (macro only), FINISH.
- IDLE: `STD_Core_A` = `CIM_Core_A`; `STDW` = `STDR` = 0.
- A command is accepted on `cmd_valid & cmd_ready`.
  - If `cmd_core == CIM_Core_A`, the command is consumed, `err` pulses next cycle, and the FSM stays in IDLE.
  - Otherwise, latch the core and swap bit, clear `verify_fail`, and go to WRITE with `STD_Core_A = cmd_core` and row counter 0.
- WRITE: each accepted beat (`w_valid & w_ready`) produces, in the next cycle, `STDW=1`, `STD_row_A=k`, `weight_in=w_data`.
  - `STDW` is 0 in any cycle following a non-accepted cycle; bubbles are allowed.
  - In the cycle after the write for row ROWS-1 (row 63), `w_ready` drops and the FSM goes to VERIFY if compiled in, else FINISH.
  - Each written row is XOR-folded into a WW-bit checksum `wsum`, cleared at command accept.
- FINISH: one cycle. `done=1`. If swap is set, `CIM_Core_A` ← loaded core in the same cycle. `STD_Core_A` follows `CIM_Core_A` from the next cycle. Then go to IDLE.
- Row counter is 6 bits and wraps 63→0 only at load end, never mid-load.
- Reset mid-operation aborts the load; the partially written core is left as is. All outputs take reset values.

## Timing
- Reset values:
  - `CIM_Core_A=INIT_CORE`, `STD_Core_A=INIT_CORE`.
  - `STDW=STDR=0`, `STD_row_A=0`, `weight_in=0`.
  - `cmd_ready=1`, `w_ready=0`.
  - `busy=done=err=verify_fail=0`.
- Command accept to `w_ready`=1: 1 cycle.
- Streaming at one beat per cycle: 64 consecutive `STDW` cycles. `done` comes 2 cycles after the last `STDW` without the macro.
- `cmd_ready` returns the cycle after `done`.
- `w_valid` while not in WRITE is ignored and the beat is not consumed.

## Configuration
- `CIM_WLOAD_VERIFY_EN` defined: VERIFY state is compiled in.
  - Issues `STDR=1` for rows 0..63 on 64 consecutive cycles, on the loaded core.
  - Captures `weight_out` RD_LAT cycles after each `STDR` and XOR-folds it into `rsum`.
  - After the last capture, sets `verify_fail=1` if `rsum != wsum`, then goes to FINISH. The swap still occurs.
  - Adds 64+RD_LAT cycles to each load.
- `CIM_WLOAD_VERIFY_EN` not defined: no VERIFY state, `STDR` is tied 0, `verify_fail` is tied 0, no checksum registers.

## Test plan
- Reset, then `cmd_core=3`, `cmd_swap=1`, 64 back-to-back beats with `w_data=k` → `STDW` rows 0..63 each carrying k, `STD_Core_A=3`; `done` once; `CIM_Core_A`=3 after FINISH.
- With `CIM_Core_A=0`, issue `cmd_core=0` → `err` pulses once; no `STDW`; `busy` stays 0.
- Random `w_valid` gaps (50%) → exactly 64 `STDW` pulses with rows strictly increasing 0..63; no duplicated or dropped beats.
- `cmd_swap=0` load to core 5 → `CIM_Core_A` unchanged at 0; `STD_Core_A` returns to 0 in IDLE.
- Assert `rst` after beat 20 → next cycle all outputs at reset values; a following full load to core 2 completes normally.
- Macro on, core model corrupts row 17 bit 0 on read → `verify_fail=1` at `done`. Then a clean reload clears `verify_fail` at accept and leaves it 0.

Source files
------------

// File: rtl/cim_weight_loader.sv
// Streams ROWS weight beats into a non-active CIM core over the STD port, then optionally swaps it in.
// Define CIM_WLOAD_VERIFY_EN to add an XOR-checksum readback pass before the swap.
module cim_weight_loader #(
  parameter int         ROWS      = 64,
  parameter int         WW        = 288,
  parameter int         RD_LAT    = 1,
  parameter logic [2:0] INIT_CORE = 3'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_core,
  input  logic          cmd_swap,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [WW-1:0] w_data,
  output logic [2:0]    CIM_Core_A,
  output logic [2:0]    STD_Core_A,
  output logic          STDW,
  output logic          STDR,
  output logic [5:0]    STD_row_A,
  output logic [WW-1:0] weight_in,
  input  logic [WW-1:0] weight_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          verify_fail
);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

`ifdef CIM_WLOAD_VERIFY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FINISH = 2'd2, VERIFY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FINISH = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            w_ready_q, w_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [2:0]      cim_core_q, cim_core_d;
  logic [2:0]      std_core_q, std_core_d;
  logic            stdw_q, stdw_d;
  logic [5:0]      row_q, row_d;
  logic [WW-1:0]   weight_in_q, weight_in_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            swap_q, swap_d;

`ifdef CIM_WLOAD_VERIFY_EN
  logic            stdr_q, stdr_d;
  logic            vfail_q, vfail_d;
  logic [5:0]      iss_q, iss_d;
  logic [5:0]      cap_q, cap_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [WW-1:0]   wsum_q, wsum_d;
  logic [WW-1:0]   rsum_q, rsum_d;
`endif

  always_comb begin
    state_d     = state_q;
    w_ready_d   = w_ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cim_core_d  = cim_core_q;
    std_core_d  = std_core_q;
    stdw_d      = 1'b0;
    row_d       = row_q;
    weight_in_d = weight_in_q;
    cnt_d       = cnt_q;
    swap_d      = swap_q;
`ifdef CIM_WLOAD_VERIFY_EN
    stdr_d  = 1'b0;
    vfail_d = vfail_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    vpipe_d = RD_LAT'({vpipe_q, stdr_q});
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
`endif
    case (state_q)
      IDLE: begin
        std_core_d = cim_core_q;
        w_ready_d  = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          // Loading the core CIM is computing on would corrupt it: consume and flag.
          if (cmd_core == cim_core_q) begin
            err_d = 1'b1;
          end else begin
            state_d    = WRITE;
            std_core_d = cmd_core;
            swap_d     = cmd_swap;
            cnt_d      = 6'd0;
            w_ready_d  = 1'b1;
`ifdef CIM_WLOAD_VERIFY_EN
            vfail_d = 1'b0;
            wsum_d  = '0;
`endif
          end
        end
      end
      WRITE: begin
        if (w_valid && w_ready_q) begin
          stdw_d      = 1'b1;
          row_d       = cnt_q;
          weight_in_d = w_data;
          cnt_d       = cnt_q + 6'd1;
          if (cnt_q == LAST_ROW) w_ready_d = 1'b0;
`ifdef CIM_WLOAD_VERIFY_EN
          wsum_d = wsum_q ^ w_data;
`endif
        end
        if (stdw_q && row_q == LAST_ROW) begin
`ifdef CIM_WLOAD_VERIFY_EN
          // Row 0 read is issued straight away so readback costs 64+RD_LAT cycles.
          state_d = VERIFY;
          stdr_d  = 1'b1;
          row_d   = 6'd0;
          iss_d   = 6'd1;
          cap_d   = 6'd0;
          rsum_d  = '0;
`else
          state_d = FINISH;
`endif
        end
      end
`ifdef CIM_WLOAD_VERIFY_EN
      VERIFY: begin
        if (iss_q != 6'd0) begin
          stdr_d = 1'b1;
          row_d  = iss_q;
          iss_d  = iss_q + 6'd1;
        end
        if (vpipe_q[RD_LAT-1]) begin
          rsum_d = rsum_q ^ weight_out;
          cap_d  = cap_q + 6'd1;
          if (cap_q == LAST_ROW) begin
            vfail_d = ((rsum_q ^ weight_out) != wsum_q);
            state_d = FINISH;
          end
        end
      end
`endif
      FINISH: begin
        done_d  = 1'b1;
        if (swap_q) cim_core_d = std_core_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready/busy lag the state by one cycle so cmd_ready reappears after done.
    cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
    busy_d      = !cmd_ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      w_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cim_core_q  <= INIT_CORE;
      std_core_q  <= INIT_CORE;
      stdw_q      <= 1'b0;
      row_q       <= 6'd0;
      weight_in_q <= '0;
      cnt_q       <= 6'd0;
      swap_q      <= 1'b0;
`ifdef CIM_WLOAD_VERIFY_EN
      stdr_q  <= 1'b0;
      vfail_q <= 1'b0;
      iss_q   <= 6'd0;
      cap_q   <= 6'd0;
      vpipe_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      w_ready_q   <= w_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cim_core_q  <= cim_core_d;
      std_core_q  <= std_core_d;
      stdw_q      <= stdw_d;
      row_q       <= row_d;
      weight_in_q <= weight_in_d;
      cnt_q       <= cnt_d;
      swap_q      <= swap_d;
`ifdef CIM_WLOAD_VERIFY_EN
      stdr_q  <= stdr_d;
      vfail_q <= vfail_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      vpipe_q <= vpipe_d;
`endif
    end
  end

`ifdef CIM_WLOAD_VERIFY_EN
  always_ff @(posedge clk) begin
    wsum_q <= wsum_d;
    rsum_q <= rsum_d;
  end

  assign STDR        = stdr_q;
  assign verify_fail = vfail_q;
`else
  logic unused_rd;
  assign unused_rd   = ^weight_out ^ (RD_LAT == 0);
  assign STDR        = 1'b0;
  assign verify_fail = 1'b0;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign w_ready    = w_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign CIM_Core_A = cim_core_q;
  assign STD_Core_A = std_core_q;
  assign STDW       = stdw_q;
  assign STD_row_A  = row_q;
  assign weight_in  = weight_in_q;
endmodule

// File: tb/tb_cim_weight_loader.sv
// Scoreboard bench for cim_weight_loader: expected row writes are queued by the stimulus
// and popped by a monitor; a small core-memory model feeds weight_out.
module tb_cim_weight_loader;
  localparam int         ROWS      = 64;
  localparam int         WW        = 288;
  localparam int         RD_LAT    = 1;
  localparam logic [2:0] INIT_CORE = 3'd0;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_swap;
  logic [2:0]    cmd_core;
  logic          w_valid, w_ready;
  logic [WW-1:0] w_data;
  logic [2:0]    CIM_Core_A, STD_Core_A;
  logic          STDW, STDR;
  logic [5:0]    STD_row_A;
  logic [WW-1:0] weight_in, weight_out;
  logic          busy, done, err, verify_fail;

  cim_weight_loader #(.ROWS(ROWS), .WW(WW), .RD_LAT(RD_LAT), .INIT_CORE(INIT_CORE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_core(cmd_core),
    .cmd_swap(cmd_swap), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .CIM_Core_A(CIM_Core_A), .STD_Core_A(STD_Core_A), .STDW(STDW), .STDR(STDR),
    .STD_row_A(STD_row_A), .weight_in(weight_in), .weight_out(weight_out), .busy(busy),
    .done(done), .err(err), .verify_fail(verify_fail));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core memory model with RD_LAT-cycle read pipe; corrupt17 flips bit 0 of row 17 on read.
  logic          corrupt17;
  logic [WW-1:0] ram [8][64];
  logic [WW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (STDW) ram[STD_Core_A][STD_row_A] <= weight_in;
    if (STDR) rd_pipe[0] <= ram[STD_Core_A][STD_row_A] ^ WW'((corrupt17 && STD_row_A == 6'd17) ? 1 : 0);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign weight_out = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic [2:0]    core;
    logic [5:0]    row;
    logic [WW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, stdr_cnt = 0, stdw_cnt = 0;
  int run = 0, last_run = 0, last_stdw_cyc = 0;
  int exp_stdr = 0;
  logic [2:0] cim_model;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
        if (STDR) stdr_cnt++;
        if (STDW) begin
          stdw_cnt++; run++; last_stdw_cyc = cyc;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stdw_unexpected: write core %0d row %0d, none expected", STD_Core_A, STD_row_A);
          end else begin
            e = exp_q.pop_front();
            if (STD_Core_A !== e.core || STD_row_A !== e.row || weight_in !== e.data) begin
              miscompares++;
              $display("FAIL stdw_write: got core %0d row %0d data %h, expected core %0d row %0d data %h",
                       STD_Core_A, STD_row_A, weight_in, e.core, e.row, e.data);
            end
          end
        end else if (run != 0) begin
          last_run = run; run = 0;
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cim_core"}, 64'(CIM_Core_A), 64'(INIT_CORE));
    chk({tag, "_std_core"}, 64'(STD_Core_A), 64'(INIT_CORE));
    chk({tag, "_stdw"}, 64'(STDW), 0);
    chk({tag, "_stdr"}, 64'(STDR), 0);
    chk({tag, "_row"}, 64'(STD_row_A), 0);
    chk({tag, "_weight_in_nz"}, 64'(|weight_in), 0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({tag, "_w_ready"}, 64'(w_ready), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_verify_fail"}, 64'(verify_fail), 0);
  endtask

  // Waits for cmd_ready, presents one command for one accepting edge; returns at the next negedge.
  task automatic send_cmd(input logic [2:0] core, input logic sw);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL cmd_ready_timeout: got 0, expected 1 within 200 cycles");
    end
    cmd_valid = 1'b1; cmd_core = core; cmd_swap = sw;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Offers beats with gap% idle cycles; beat k is expected to land in row k of the loaded core.
  task automatic send_beats(input logic [2:0] core, input int gap, input int nbeats, input bit ramp);
    int k = 0, n = 0;
    logic [WW-1:0] d;
    while (k < nbeats && n < 5000) begin
      if ($urandom_range(99) < gap) begin
        w_valid = 1'b0;
      end else begin
        d = '0;
        if (ramp) d[31:0] = k;
        else for (int j = 0; j < WW / 32; j++) d[j*32 +: 32] = $urandom;
        w_valid = 1'b1; w_data = d;
      end
      if (w_valid && w_ready) begin
        exp_q.push_back('{core, 6'(k), w_data});
        k++;
      end
      @(negedge clk); n++;
    end
    w_valid = 1'b0;
    if (k < nbeats) begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout: got %0d beats accepted, expected %0d", k, nbeats);
    end
  endtask

  task automatic run_load(input logic [2:0] core, input logic sw, input int gap, input bit ramp,
                          input logic vf_exp);
    int d0 = done_cnt, s0 = stdw_cnt, n = 0;
    send_cmd(core, sw);
    chk("w_ready_after_accept", 64'(w_ready), 1);
    chk("std_core_in_load", 64'(STD_Core_A), 64'(core));
    chk("verify_fail_clear_at_accept", 64'(verify_fail), 0);
    send_beats(core, gap, ROWS, ramp);
    while (!done && n < 400) begin @(negedge clk); n++; end
    chk("done_seen", 64'(done), 1);
    if (sw) cim_model = core;
    chk("cim_core_at_done", 64'(CIM_Core_A), 64'(cim_model));
    chk("cmd_ready_low_at_done", 64'(cmd_ready), 0);
    chk("verify_fail_at_done", 64'(verify_fail), 64'(vf_exp));
`ifdef CIM_WLOAD_VERIFY_EN
    chk("done_latency", 64'(cyc - last_stdw_cyc), 64'(2 + ROWS + RD_LAT));
    exp_stdr += ROWS;
`else
    chk("done_latency", 64'(cyc - last_stdw_cyc), 2);
`endif
    if (gap == 0) chk("consecutive_stdw", 64'(last_run), 64'(ROWS));
    @(negedge clk);
    chk("cmd_ready_after_done", 64'(cmd_ready), 1);
    chk("busy_after_done", 64'(busy), 0);
    chk("std_core_follows_cim", 64'(STD_Core_A), 64'(cim_model));
    chk("stdw_count", 64'(stdw_cnt - s0), 64'(ROWS));
    chk("done_count", 64'(done_cnt - d0), 1);
    chk("writes_outstanding", 64'(exp_q.size()), 0);
  endtask

  initial begin
    int e0, s0, b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_core = '0; cmd_swap = 1'b0;
    w_valid = 1'b0; w_data = '0; corrupt17 = 1'b0;
    cim_model = INIT_CORE;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Command to the active core is rejected; stray w_valid in IDLE is ignored.
    e0 = err_cnt; s0 = stdw_cnt; b0 = busy_cnt;
    w_valid = 1'b1; w_data = '1;
    send_cmd(cim_model, 1'b1);
    chk("err_pulse", 64'(err), 1);
    repeat (3) @(negedge clk);
    w_valid = 1'b0;
    chk("err_count", 64'(err_cnt - e0), 1);
    chk("err_no_stdw", 64'(stdw_cnt - s0), 0);
    chk("err_busy_stays_low", 64'(busy_cnt - b0), 0);
    chk("err_cmd_ready", 64'(cmd_ready), 1);

    run_load(3'd5, 1'b0, 50, 1'b0, 1'b0);
    run_load(3'd3, 1'b1, 0, 1'b1, 1'b0);
    run_load(3'd1, 1'b0, 30, 1'b0, 1'b0);

    // Abort a load with reset after beat 20.
    send_cmd(3'd6, 1'b1);
    send_beats(3'd6, 0, 21, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midload");
    chk("midload_writes_outstanding", 64'(exp_q.size()), 0);
    exp_q.delete();
    rst = 1'b0;
    cim_model = INIT_CORE;
    run_load(3'd2, 1'b1, 0, 1'b0, 1'b0);

`ifdef CIM_WLOAD_VERIFY_EN
    corrupt17 = 1'b1;
    run_load(3'd4, 1'b1, 20, 1'b0, 1'b1);
    chk("verify_fail_sticky", 64'(verify_fail), 1);
    corrupt17 = 1'b0;
    run_load(3'd6, 1'b1, 0, 1'b0, 1'b0);
`endif
    chk("stdr_total", 64'(stdr_cnt), 64'(exp_stdr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
